// File: rtl/iccm_boot_loader.sv
// ---------------------------------------------------------------------------
// iccm_boot_loader
//
// Sits in front of the ICCM adapter's programming port. It takes validated
// bytes from the UART programming receiver and parses one framed image:
//
//    SyncByte | len[7:0] | len[15:8] | 4*len payload bytes (LE) | checksum
//
// The payload is packed into 32-bit words and each completed word becomes a
// one-cycle ICCM write strobe. The checksum is the mod-256 sum of the payload
// bytes. The programming reset is held low from the start of a load, and it
// is released only after the checksum matches.
//
// Ports
//    clk_i      system clock
//    rst_ni     asynchronous active-low reset
//    prog_i     asynchronous programming-mode pin (2-flop synchronised)
//    rx_dv_i    one-cycle pulse, rx_byte_i valid
//    rx_byte_i  received byte
//    we_o       one-cycle ICCM write strobe
//    addr_o     ICCM word address of the current write (held when idle)
//    wdata_o    ICCM write data (held when idle)
//    reset_o    programming reset to the reset manager, active low
//    done_o     level: last frame verified
//    err_o      level: last frame failed
// ---------------------------------------------------------------------------
module iccm_boot_loader #(
   parameter int unsigned AddrWidth     = 12,
   parameter int unsigned MaxWords      = 1024,
   parameter logic [7:0]  SyncByte      = 8'hA5,
   parameter int unsigned TimeoutCycles = 1000000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 prog_i,
   input  logic                 rx_dv_i,
   input  logic [7:0]           rx_byte_i,
   output logic                 we_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic [31:0]          wdata_o,
   output logic                 reset_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int unsigned     TmoW    = $clog2(TimeoutCycles + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
   localparam logic [15:0]     MaxLen  = 16'(MaxWords);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_DATA   = 3'd4,
      ST_CSUM   = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } state_e;

   // Running payload checksum: plain 8-bit sum, carries discarded.
   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
      return sum + data;
   endfunction

   // Synchroniser and edge-detect history for prog_i.
   logic prog_meta_r, prog_sync_r, prog_q_r;
   logic prog_rise_s, prog_fall_s;

   state_e                 state_r,      state_nxt;
   logic [7:0]             len_lo_r,     len_lo_nxt;
   logic [15:0]            words_left_r, words_left_nxt;
   logic [AddrWidth-1:0]   word_idx_r,   word_idx_nxt;
   logic [1:0]             byte_cnt_r,   byte_cnt_nxt;
   logic [23:0]            shift_r,      shift_nxt;
   logic [7:0]             csum_r,       csum_nxt;
   logic [TmoW-1:0]        tmo_cnt_r,    tmo_cnt_nxt;
   logic                   we_r,         we_nxt;
   logic [AddrWidth-1:0]   addr_r,       addr_nxt;
   logic [31:0]            wdata_r,      wdata_nxt;
   logic                   reset_r,      reset_nxt;
   logic                   done_r,       done_nxt;
   logic                   err_r,        err_nxt;

   logic        in_frame_s;
   logic        tmo_hit_s;
   logic [15:0] len_s;

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prog_meta_r <= 1'b0;
         prog_sync_r <= 1'b0;
         prog_q_r    <= 1'b0;
      end else begin
         prog_meta_r <= prog_i;
         prog_sync_r <= prog_meta_r;
         prog_q_r    <= prog_sync_r;
      end
   end

   assign prog_rise_s = prog_sync_r & ~prog_q_r;
   assign prog_fall_s = ~prog_sync_r & prog_q_r;

   // The idle timeout and prog abort only apply once the sync byte is seen.
   assign in_frame_s = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                       (state_r == ST_DATA)   || (state_r == ST_CSUM);
   assign tmo_hit_s  = in_frame_s && !rx_dv_i && (tmo_cnt_r == TmoLast);
   assign len_s      = {rx_byte_i, len_lo_r};

   // Next-state and next-datapath logic for the frame parser.
   always_comb begin
      state_nxt      = state_r;
      len_lo_nxt     = len_lo_r;
      words_left_nxt = words_left_r;
      word_idx_nxt   = word_idx_r;
      byte_cnt_nxt   = byte_cnt_r;
      shift_nxt      = shift_r;
      csum_nxt       = csum_r;
      tmo_cnt_nxt    = tmo_cnt_r;
      we_nxt         = 1'b0;
      addr_nxt       = addr_r;
      wdata_nxt      = wdata_r;
      reset_nxt      = reset_r;
      done_nxt       = done_r;
      err_nxt        = err_r;

      if (prog_rise_s) begin
         // A new load always wins, even over a byte arriving this cycle.
         state_nxt      = ST_SYNC;
         reset_nxt      = 1'b0;
         done_nxt       = 1'b0;
         err_nxt        = 1'b0;
         len_lo_nxt     = 8'h00;
         words_left_nxt = 16'h0000;
         word_idx_nxt   = '0;
         byte_cnt_nxt   = 2'd0;
         shift_nxt      = 24'h000000;
         csum_nxt       = 8'h00;
         tmo_cnt_nxt    = '0;
      end else if (in_frame_s && (prog_fall_s || tmo_hit_s)) begin
         // Abort: the partial word in shift_r is simply never written.
         state_nxt = ST_ERR;
         err_nxt   = 1'b1;
         done_nxt  = 1'b0;
         reset_nxt = 1'b0;
      end else begin
         if (in_frame_s) begin
            if (rx_dv_i) begin
               tmo_cnt_nxt = '0;
            end else begin
               tmo_cnt_nxt = tmo_cnt_r + TmoW'(1'b1);
            end
         end else begin
            tmo_cnt_nxt = tmo_cnt_r;
         end

         case (state_r)
            ST_SYNC: begin
               if (rx_dv_i && (rx_byte_i == SyncByte)) begin
                  state_nxt = ST_LEN_LO;
               end else begin
                  state_nxt = ST_SYNC;
               end
            end
            ST_LEN_LO: begin
               if (rx_dv_i) begin
                  len_lo_nxt = rx_byte_i;
                  state_nxt  = ST_LEN_HI;
               end else begin
                  state_nxt  = ST_LEN_LO;
               end
            end
            ST_LEN_HI: begin
               if (rx_dv_i) begin
                  if (len_s > MaxLen) begin
                     state_nxt = ST_ERR;
                     err_nxt   = 1'b1;
                     done_nxt  = 1'b0;
                     reset_nxt = 1'b0;
                  end else if (len_s == 16'h0000) begin
                     state_nxt = ST_CSUM;
                  end else begin
                     state_nxt      = ST_DATA;
                     words_left_nxt = len_s;
                  end
               end else begin
                  state_nxt = ST_LEN_HI;
               end
            end
            ST_DATA: begin
               if (rx_dv_i) begin
                  csum_nxt = csum_add(csum_r, rx_byte_i);
                  if (byte_cnt_r == 2'd3) begin
                     // Fourth byte completes the word: strobe next cycle.
                     we_nxt       = 1'b1;
                     wdata_nxt    = {rx_byte_i, shift_r};
                     addr_nxt     = word_idx_r;
                     word_idx_nxt = word_idx_r + AddrWidth'(1'b1);
                     byte_cnt_nxt = 2'd0;
                     if (words_left_r == 16'h0001) begin
                        state_nxt      = ST_CSUM;
                        words_left_nxt = 16'h0000;
                     end else begin
                        state_nxt      = ST_DATA;
                        words_left_nxt = words_left_r - 16'h0001;
                     end
                  end else begin
                     // Little-endian: the newest byte enters at the top.
                     shift_nxt    = {rx_byte_i, shift_r[23:8]};
                     byte_cnt_nxt = byte_cnt_r + 2'd1;
                  end
               end else begin
                  state_nxt = ST_DATA;
               end
            end
            ST_CSUM: begin
               if (rx_dv_i) begin
                  if (rx_byte_i == csum_r) begin
                     state_nxt = ST_DONE;
                     reset_nxt = 1'b1;
                     done_nxt  = 1'b1;
                     err_nxt   = 1'b0;
                  end else begin
                     state_nxt = ST_ERR;
                     err_nxt   = 1'b1;
                     done_nxt  = 1'b0;
                     reset_nxt = 1'b0;
                  end
               end else begin
                  state_nxt = ST_CSUM;
               end
            end
            ST_IDLE, ST_DONE, ST_ERR: begin
               state_nxt = state_r;
            end
            default: begin
               // Unreachable encoding: fail safe with the core held.
               state_nxt = ST_ERR;
               err_nxt   = 1'b1;
               done_nxt  = 1'b0;
               reset_nxt = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         len_lo_r     <= 8'h00;
         words_left_r <= 16'h0000;
         word_idx_r   <= '0;
         byte_cnt_r   <= 2'd0;
         shift_r      <= 24'h000000;
         csum_r       <= 8'h00;
         tmo_cnt_r    <= '0;
         we_r         <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= 32'h00000000;
         reset_r      <= 1'b1;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         len_lo_r     <= len_lo_nxt;
         words_left_r <= words_left_nxt;
         word_idx_r   <= word_idx_nxt;
         byte_cnt_r   <= byte_cnt_nxt;
         shift_r      <= shift_nxt;
         csum_r       <= csum_nxt;
         tmo_cnt_r    <= tmo_cnt_nxt;
         we_r         <= we_nxt;
         addr_r       <= addr_nxt;
         wdata_r      <= wdata_nxt;
         reset_r      <= reset_nxt;
         done_r       <= done_nxt;
         err_r        <= err_nxt;
      end
   end

   assign we_o    = we_r;
   assign addr_o  = addr_r;
   assign wdata_o = wdata_r;
   assign reset_o = reset_r;
   assign done_o  = done_r;
   assign err_o   = err_r;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_iccm_boot_loader
//
// Directed and randomised frames are fed into iccm_boot_loader. A reference
// model derives the expected ICCM writes and the verdict from the frame
// contents alone. Every strobe is captured on the falling clock edge and
// compared with that model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iccm_boot_loader;

   localparam int AW  = 12;
   localparam int MW  = 1024;
   localparam int TMO = 100;

   typedef logic [7:0]      bq_t[$];
   typedef logic [AW+31:0]  wq_t[$];

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prog;
   logic          rx_dv;
   logic [7:0]    rx_byte;
   logic          we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          core_rst_n;
   logic          done;
   logic          err;

   int  checks = 0;
   int  errors = 0;
   wq_t obs_q;

   iccm_boot_loader #(
      .AddrWidth     (AW),
      .MaxWords      (MW),
      .SyncByte      (8'hA5),
      .TimeoutCycles (TMO)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .prog_i    (prog),
      .rx_dv_i   (rx_dv),
      .rx_byte_i (rx_byte),
      .we_o      (we),
      .addr_o    (addr),
      .wdata_o   (wdata),
      .reset_o   (core_rst_n),
      .done_o    (done),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   // Capture every write strobe away from the active edge.
   always @(negedge clk) begin
      if (we === 1'b1) obs_q.push_back({addr, wdata});
   end

   // Safety net in case the run stalls.
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bq_t q, input int gap);
      foreach (q[i]) begin
         rx_dv   = 1'b1;
         rx_byte = q[i];
         @(posedge clk);
         #1;
         rx_dv = 1'b0;
         if (gap > 0) cyc(gap);
      end
      rx_dv = 1'b0;
   endtask

   // Low-then-high on prog starts a fresh load.
   task automatic restart();
      prog = 1'b0;
      cyc(4);
      prog = 1'b1;
      cyc(4);
      obs_q.delete();
   endtask

   // Reference: word i is payload bytes 4i..4i+3, little-endian, at address i.
   function automatic wq_t model_writes(input logic [15:0] len, input bq_t pl);
      wq_t w;
      logic [31:0] word;
      w = {};
      if (int'(len) <= MW) begin
         for (int i = 0; i < int'(len); i++) begin
            word = 32'(pl[4*i]) + (32'(pl[4*i+1]) << 8) +
                   (32'(pl[4*i+2]) << 16) + (32'(pl[4*i+3]) << 24);
            w.push_back({AW'(i), word});
         end
      end
      return w;
   endfunction

   function automatic logic [7:0] model_sum(input bq_t pl);
      int s;
      s = 0;
      foreach (pl[i]) s = (s + int'(pl[i])) % 256;
      return 8'(s);
   endfunction

   function automatic bq_t rand_payload(input int nbytes);
      bq_t q;
      q = {};
      for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   // Sends one complete frame and compares writes and verdict with the model.
   task automatic do_frame(input string tag, input logic [15:0] len, input bq_t pl,
                           input logic [7:0] cs, input int gap);
      bq_t  hdr;
      bq_t  tail;
      wq_t  exp;
      logic ok;
      hdr = {};
      hdr.push_back(8'hA5);
      hdr.push_back(len[7:0]);
      hdr.push_back(len[15:8]);
      send(hdr, gap);
      if (int'(len) <= MW) begin
         send(pl, gap);
         check({tag, "_held"}, 64'(core_rst_n), 64'(1'b0));
         tail = {};
         tail.push_back(cs);
         send(tail, gap);
      end
      cyc(3);
      exp = model_writes(len, pl);
      ok  = (int'(len) <= MW) && (cs == model_sum(pl));
      check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp.size()));
      foreach (exp[i]) begin
         if (i < obs_q.size()) check({tag, "_wr"}, 64'(obs_q[i]), 64'(exp[i]));
      end
      check({tag, "_done"}, 64'(done), 64'(ok));
      check({tag, "_err"}, 64'(err), 64'(!ok));
      check({tag, "_rst"}, 64'(core_rst_n), 64'(ok));
      obs_q.delete();
   endtask

   initial begin
      bq_t         pl;
      bq_t         s;
      logic [15:0] len;
      logic [7:0]  cs;

      rst_n   = 1'b0;
      prog    = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      cyc(2);
      check("rst_we",    64'(we),         64'(1'b0));
      check("rst_addr",  64'(addr),       64'(0));
      check("rst_wdata", 64'(wdata),      64'(0));
      check("rst_reset", 64'(core_rst_n), 64'(1'b1));
      check("rst_done",  64'(done),       64'(1'b0));
      check("rst_err",   64'(err),        64'(1'b0));
      rst_n = 1'b1;
      cyc(2);

      // Nominal two-word load from the worked example.
      restart();
      check("nom_rst_low", 64'(core_rst_n), 64'(1'b0));
      pl = {};
      for (int i = 1; i <= 8; i++) pl.push_back(8'(8'h11 * i));
      do_frame("nom", 16'd2, pl, 8'h64, 0);

      // Same frame, wrong checksum.
      restart();
      do_frame("badcs", 16'd2, pl, 8'h65, 1);

      // Oversize length is rejected straight after the length bytes.
      restart();
      pl = {};
      do_frame("over", 16'h0401, pl, 8'h00, 0);

      // Empty image.
      restart();
      do_frame("zero", 16'h0000, pl, 8'h00, 0);

      // Largest legal image, back-to-back.
      restart();
      pl = rand_payload(4 * MW);
      do_frame("max", 16'(MW), pl, model_sum(pl), 0);

      // Noise before sync, then an idle gap mid-data.
      restart();
      s = {};
      s.push_back(8'h00); s.push_back(8'hFF); s.push_back(8'hA5);
      s.push_back(8'h01); s.push_back(8'h00); s.push_back(8'h11);
      send(s, 0);
      cyc(TMO / 2);
      check("tmo_early", 64'(err), 64'(1'b0));
      cyc(TMO / 2 + 10);
      check("tmo_err",  64'(err),          64'(1'b1));
      check("tmo_nwr",  64'(obs_q.size()), 64'(0));
      check("tmo_rst",  64'(core_rst_n),   64'(1'b0));
      check("tmo_done", 64'(done),         64'(1'b0));

      // prog dropped mid-word, then reload.
      restart();
      s = {};
      s.push_back(8'hA5); s.push_back(8'h01); s.push_back(8'h00);
      s.push_back(8'h11); s.push_back(8'h22);
      send(s, 0);
      prog = 1'b0;
      cyc(4);
      check("abort_err", 64'(err),        64'(1'b1));
      check("abort_rst", 64'(core_rst_n), 64'(1'b0));
      s = {};
      s.push_back(8'h33); s.push_back(8'h44);
      send(s, 0);
      cyc(2);
      check("abort_nwr", 64'(obs_q.size()), 64'(0));
      prog = 1'b1;
      cyc(4);
      obs_q.delete();
      check("reload_errclr", 64'(err), 64'(1'b0));
      pl = rand_payload(4);
      do_frame("reload", 16'd1, pl, model_sum(pl), 0);

      // Randomised frames, some with a corrupted checksum.
      for (int k = 0; k < 8; k++) begin
         restart();
         len = 16'($urandom_range(1, 6));
         pl  = rand_payload(4 * int'(len));
         cs  = model_sum(pl);
         if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
         do_frame("rand", len, pl, cs, int'($urandom_range(0, 3)));
      end

      // Four words with a byte on every cycle.
      restart();
      pl = rand_payload(16);
      do_frame("b2b", 16'd4, pl, model_sum(pl), 0);

      // Asynchronous reset in the middle of a data phase.
      restart();
      s = {};
      s.push_back(8'hA5); s.push_back(8'h04); s.push_back(8'h00);
      for (int i = 0; i < 6; i++) s.push_back(8'($urandom_range(0, 255)) | 8'h01);
      send(s, 0);
      cyc(1);
      check("mid_nwr", 64'(obs_q.size()), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_we",    64'(we),         64'(1'b0));
      check("mid_addr",  64'(addr),       64'(0));
      check("mid_wdata", 64'(wdata),      64'(0));
      check("mid_reset", 64'(core_rst_n), 64'(1'b1));
      check("mid_done",  64'(done),       64'(1'b0));
      check("mid_err",   64'(err),        64'(1'b0));
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
